cmd_issue_arbiter: RTL
======================

# cmd_issue_arbiter

Shares the issue-FIFO write port among the per-bank command queues of the command scheduler. Each cycle it selects one eligible bank request round-robin and enforces the global inter-bank spacing rules tRRD (ACT to ACT) and tCCD (column to column). It honours the FIFO's full/virtual_full back-pressure and sequences refresh: drain the FIFO, then insert one REF command. Output is a registered `{cmd, addr, bank}` write into the issue FIFO.

## Interface

- NUM_BANK, 8: number of requesting bank queues; bank field width is 3.
- CMD_W, 4: command field width.
- ADDR_W, 14: address field width.
- T_RRD, 4: minimum cycles between consecutive ACT grants; must be at least 1.
- T_CCD, 4: minimum cycles between consecutive READ/WRITE grants; must be at least 1.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_BANK  bank i has a command pending.
- req_cmd  in  NUM_BANK*CMD_W  command of bank i, slice [i*CMD_W +: CMD_W]. Encodings: NOP=0, ACT=1, READ=2, WRITE=3, PRE=4, REF=5.
- req_addr  in  NUM_BANK*ADDR_W  address of bank i, slice [i*ADDR_W +: ADDR_W].
- req_grant  out  NUM_BANK  one-hot and combinational; the bank pops its queue on the same edge.
- ref_req  in  1  refresh request level; held until ref_ack.
- ref_ack  out  1  one-cycle pulse, coincident with the REF write.
- fifo_full, fifo_virtual_full, fifo_empty  in  1 each  issue-FIFO status.
- fifo_wen  out  1  registered FIFO write enable.
- fifo_data  out  CMD_W+ADDR_W+3  registered `{cmd, addr, bank}`.
- stall_cnt  out  16  saturating count of cycles with at least one req_valid and no grant.

## Operation

- States: ARB, REF_DRAIN, REF_ISSUE. Reset state is ARB.
- Eligibility of bank i: req_valid[i] is 1 and one of the following holds:
  - cmd is ACT and rrd_cnt==0;
  - cmd is READ/WRITE and ccd_cnt==0;
  - cmd is any other value.
- Grant is allowed only when all of: state==ARB, ref_req==0, fifo_virtual_full==0, fifo_full==0.
- Grant selection: the first eligible bank searched from rr_ptr upward, modulo NUM_BANK. At most one grant per cycle.
- On a grant to bank g:
  - rr_ptr <= (g+1) mod NUM_BANK;
  - output register <= {req_cmd[g], req_addr[g], g} and fifo_wen <= 1.
- Otherwise fifo_wen <= 0. fifo_data holds its last value.
- Spacing counters:
  - On an ACT grant, rrd_cnt <= T_RRD-1; otherwise it decrements, saturating at 0.
  - On a READ/WRITE grant, ccd_cnt <= T_CCD-1; otherwise it decrements, saturating at 0.
  - Both counters keep counting in every state.
- ARB to REF_DRAIN: when ref_req==1. Grants are already blocked combinationally in that cycle.
- REF_DRAIN to REF_ISSUE: when fifo_empty==1 and fifo_wen==0 (no write in flight).
- REF_ISSUE:
  - If fifo_full==0, load {REF, 0, 3'd0}, set fifo_wen <= 1 and ref_ack <= 1, then go to ARB.
  - Otherwise stay in REF_ISSUE.
- stall_cnt increments when |req_valid and no grant; it holds at 16'hFFFF.
- Reset mid-operation: all state returns to reset values at the next edge, and any pending refresh is dropped. The requester must re-assert ref_req.

## Timing

- Reset values: fifo_wen=0, fifo_data=0, ref_ack=0, stall_cnt=0, rr_ptr=0, rrd_cnt=0, ccd_cnt=0, state=ARB.
- req_grant is 0 while rst_n==0.
- Latency: a grant in cycle N produces fifo_wen=1 with matching fifo_data in cycle N+1. Back-to-back grants give one write per cycle.
- Back-pressure slack: one write can be in flight after fifo_virtual_full rises. The FIFO's virtual_full margin covers this.
- Spacing: an ACT grant at cycle N blocks the next ACT grant until cycle N+T_RRD. The same rule applies to tCCD for READ/WRITE.
- ref_ack rises in the same cycle as fifo_wen for the REF write, at least 2 cycles after ref_req is first seen.
- Simultaneous events: if ref_req and req_valid are both high in ARB, refresh wins and there is no grant that cycle.

## Test plan

- Round-robin: all 8 banks request READ; T_CCD=1; FIFO never full. Required: grants go 0,1,…,7,0. fifo_data.bank follows one cycle later. No gaps between writes.
- tRRD: banks 2 and 5 both request ACT at cycle 10 with T_RRD=4. Required: bank 2 granted at cycle 10, bank 5 at cycle 14. A PRE from bank 3 is granted at cycle 11.
- Back-pressure: fifo_virtual_full=1 for cycles 20–25 with req_valid=8'hFF. Required: no grants and no writes after cycle 21; stall_cnt increases by 6; grants resume at cycle 26.
- Refresh: ref_req=1 at cycle 30; FIFO drains and fifo_empty=1 at cycle 40. Required:
  - no grants from cycle 30;
  - state REF_ISSUE at cycle 41;
  - fifo_wen=1 and ref_ack=1 with fifo_data={5, 0, 0} at cycle 42;
  - grants resume at cycle 42 once ref_req drops.
- Reset mid-refresh: rst_n=0 while in REF_DRAIN. Required: state=ARB, fifo_wen=0, ref_ack=0, stall_cnt=0, rr_ptr=0 at the next edge.
- Saturation: hold req_valid=1 with fifo_full=1 for 70000 cycles. Required: stall_cnt==16'hFFFF and no wrap.

Source files
------------

// File: rtl/cmd_issue_arbiter.sv
// Issue-FIFO write-port arbiter: round-robin bank selection with tRRD/tCCD
// spacing, FIFO back-pressure and a drain-then-REF refresh sequence.
module cmd_issue_arbiter #(
    parameter int unsigned NUM_BANK = 8,
    parameter int unsigned CMD_W    = 4,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned T_RRD    = 4,
    parameter int unsigned T_CCD    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANK-1:0]           req_valid,
    input  logic [NUM_BANK*CMD_W-1:0]     req_cmd,
    input  logic [NUM_BANK*ADDR_W-1:0]    req_addr,
    output logic [NUM_BANK-1:0]           req_grant,
    input  logic                          ref_req,
    output logic                          ref_ack,
    input  logic                          fifo_full,
    input  logic                          fifo_virtual_full,
    input  logic                          fifo_empty,
    output logic                          fifo_wen,
    output logic [CMD_W+ADDR_W+2:0]       fifo_data,
    output logic [15:0]                   stall_cnt
);

    localparam int unsigned BANK_W  = 3;
    localparam int unsigned RRD_W   = (T_RRD > 1) ? $clog2(T_RRD) : 1;
    localparam int unsigned CCD_W   = (T_CCD > 1) ? $clog2(T_CCD) : 1;
    localparam int unsigned STALL_W = 16;

    localparam logic [CMD_W-1:0] CMD_ACT   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_REF   = CMD_W'(5);

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [BANK_W-1:0] bank;
    } fifo_word_t;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_REF_DRAIN = 2'd1,
        ST_REF_ISSUE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BANK_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [RRD_W-1:0]     rrd_cnt_q, rrd_cnt_d;
    logic [CCD_W-1:0]     ccd_cnt_q, ccd_cnt_d;
    fifo_word_t           fifo_data_q, fifo_data_d;
    logic                 fifo_wen_q, fifo_wen_d;
    logic                 ref_ack_q, ref_ack_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [CMD_W-1:0]     bank_cmd  [NUM_BANK];
    logic [ADDR_W-1:0]    bank_addr [NUM_BANK];
    logic [NUM_BANK-1:0]  eligible;
    logic                 grant_ok;
    logic                 gnt_found;
    logic                 gnt_valid;
    logic [BANK_W-1:0]    gnt_idx;
    logic [BANK_W-1:0]    cand;
    logic [CMD_W-1:0]     gnt_cmd;

    // Unpack per-bank fields and apply the spacing rules to each request
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            bank_cmd[i]  = req_cmd[i*CMD_W +: CMD_W];
            bank_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
            if (bank_cmd[i] == CMD_ACT) begin
                eligible[i] = req_valid[i] && (rrd_cnt_q == '0);
            end else if (bank_cmd[i] == CMD_READ || bank_cmd[i] == CMD_WRITE) begin
                eligible[i] = req_valid[i] && (ccd_cnt_q == '0);
            end else begin
                eligible[i] = req_valid[i];
            end
        end
    end

    // Round-robin pick of the first eligible bank at or above rr_ptr
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_BANK; k++) begin
            cand = BANK_W'((32'(rr_ptr_q) + k) % NUM_BANK);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        grant_ok  = rst_n && (state_q == ST_ARB) && !ref_req
                    && !fifo_virtual_full && !fifo_full;
        gnt_valid = grant_ok && gnt_found;
        gnt_cmd   = bank_cmd[gnt_idx];
        req_grant = '0;
        if (gnt_valid) begin
            req_grant[gnt_idx] = 1'b1;
        end
    end

    // Next-state: refresh sequencing, output word, spacing counters, stall count
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        fifo_wen_d  = 1'b0;
        fifo_data_d = fifo_data_q;
        ref_ack_d   = 1'b0;
        rrd_cnt_d   = (rrd_cnt_q != '0) ? rrd_cnt_q - RRD_W'(1) : '0;
        ccd_cnt_d   = (ccd_cnt_q != '0) ? ccd_cnt_q - CCD_W'(1) : '0;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_ARB: begin
                if (ref_req) begin
                    state_d = ST_REF_DRAIN;
                end else if (gnt_valid) begin
                    rr_ptr_d         = BANK_W'((32'(gnt_idx) + 1) % NUM_BANK);
                    fifo_wen_d       = 1'b1;
                    fifo_data_d.cmd  = gnt_cmd;
                    fifo_data_d.addr = bank_addr[gnt_idx];
                    fifo_data_d.bank = gnt_idx;
                    if (gnt_cmd == CMD_ACT) begin
                        rrd_cnt_d = RRD_W'(T_RRD - 1);
                    end
                    if (gnt_cmd == CMD_READ || gnt_cmd == CMD_WRITE) begin
                        ccd_cnt_d = CCD_W'(T_CCD - 1);
                    end
                end
            end
            ST_REF_DRAIN: begin
                // Wait until the FIFO is empty and our last write has landed
                if (fifo_empty && !fifo_wen_q) begin
                    state_d = ST_REF_ISSUE;
                end
            end
            ST_REF_ISSUE: begin
                if (!fifo_full) begin
                    fifo_wen_d       = 1'b1;
                    ref_ack_d        = 1'b1;
                    fifo_data_d.cmd  = CMD_REF;
                    fifo_data_d.addr = '0;
                    fifo_data_d.bank = '0;
                    state_d          = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        if ((|req_valid) && !gnt_valid && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            rrd_cnt_q   <= '0;
            ccd_cnt_q   <= '0;
            fifo_wen_q  <= 1'b0;
            fifo_data_q <= '0;
            ref_ack_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rrd_cnt_q   <= rrd_cnt_d;
            ccd_cnt_q   <= ccd_cnt_d;
            fifo_wen_q  <= fifo_wen_d;
            fifo_data_q <= fifo_data_d;
            ref_ack_q   <= ref_ack_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fifo_wen  = fifo_wen_q;
    assign fifo_data = fifo_data_q;
    assign ref_ack   = ref_ack_q;
    assign stall_cnt = stall_cnt_q;

endmodule
